// File: rtl/mole_round_controller.sv
// rtl/mole_round_controller.sv - whac-a-mole round sequencer: countdown, hit-window ramp, lives, game over
//
// Optional feature macro: MOLE_ROUND_EXTRA_LIFE_EN (every 20th hit grants a life, capped at LIVES)
//
// Ports:
//   clk              system clock
//   rst_n            asynchronous active-low reset
//   start            single-cycle pulse, begins a game from IDLE
//   abort            single-cycle pulse, returns to IDLE from any state
//   level            one-hot difficulty (001/010/100), latched on start
//   fsm_hit          pulse from mole FSM, mole hit
//   fsm_miss         pulse from mole FSM, mole timed out
//   window_ms        current hit window in ms, fed to the timeout timer
//   window_load      one-cycle pulse telling the timer to reload window_ms
//   game_active      high while playing, gates the mole FSM
//   countdown_digit  seconds remaining during the countdown, else 0
//   lives            lives remaining
//   game_over        high once the last life is lost
module mole_round_controller #(
    parameter int TICK_CYCLES   = 50000,
    parameter int COUNTDOWN_S   = 3,
    parameter int LIVES         = 3,
    parameter int RAMP_HITS     = 5,
    parameter int STEP_MS       = 100,
    parameter int MIN_WINDOW_MS = 300
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [2:0]  level,
    input  logic        fsm_hit,
    input  logic        fsm_miss,
    output logic [15:0] window_ms,
    output logic        window_load,
    output logic        game_active,
    output logic [3:0]  countdown_digit,
    output logic [1:0]  lives,
    output logic        game_over
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNTDOWN,
        S_PLAY,
        S_OVER
    } state_t;

    state_t      state;
    logic [15:0] base_window;
    logic [15:0] tick_cnt;
    logic [9:0]  ms_cnt;
    logic [7:0]  ramp_cnt;
    logic [15:0] ramped_window;

`ifdef MOLE_ROUND_EXTRA_LIFE_EN
    logic [15:0] hit_total;
    logic [15:0] hit_total_next;
    logic        life_grant;

    assign hit_total_next = hit_total + 16'd1;
    assign life_grant     = (hit_total_next % 16'd20) == 16'd0;
`endif

    function automatic logic [15:0] base_of(input logic [2:0] lvl);
        case (lvl)
            3'b010:  base_of = 16'd1200;
            3'b100:  base_of = 16'd700;
            default: base_of = 16'd2000;
        endcase
    endfunction

    // Clamp to the floor instead of letting the subtraction wrap.
    always_comb begin
        ramped_window = 16'(MIN_WINDOW_MS);
        if ({1'b0, window_ms} >= (17'(MIN_WINDOW_MS) + 17'(STEP_MS)))
            ramped_window = window_ms - 16'(STEP_MS);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            base_window     <= 16'd0;
            tick_cnt        <= 16'd0;
            ms_cnt          <= 10'd0;
            ramp_cnt        <= 8'd0;
            window_ms       <= 16'd0;
            window_load     <= 1'b0;
            game_active     <= 1'b0;
            countdown_digit <= 4'd0;
            lives           <= 2'd0;
            game_over       <= 1'b0;
`ifdef MOLE_ROUND_EXTRA_LIFE_EN
            hit_total       <= 16'd0;
`endif
        end else if (abort) begin
            state           <= S_IDLE;
            base_window     <= 16'd0;
            tick_cnt        <= 16'd0;
            ms_cnt          <= 10'd0;
            ramp_cnt        <= 8'd0;
            window_ms       <= 16'd0;
            window_load     <= 1'b0;
            game_active     <= 1'b0;
            countdown_digit <= 4'd0;
            lives           <= 2'd0;
            game_over       <= 1'b0;
`ifdef MOLE_ROUND_EXTRA_LIFE_EN
            hit_total       <= 16'd0;
`endif
        end else begin
            window_load <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        base_window     <= base_of(level);
                        lives           <= 2'(LIVES);
                        countdown_digit <= 4'(COUNTDOWN_S);
                        tick_cnt        <= 16'd0;
                        ms_cnt          <= 10'd0;
                        ramp_cnt        <= 8'd0;
`ifdef MOLE_ROUND_EXTRA_LIFE_EN
                        hit_total       <= 16'd0;
`endif
                        state           <= S_COUNTDOWN;
                    end
                end

                S_COUNTDOWN: begin
                    // tick_cnt divides clk to 1 ms; ms_cnt divides ms to seconds.
                    if (tick_cnt == 16'(TICK_CYCLES - 1)) begin
                        tick_cnt <= 16'd0;
                        if (ms_cnt == 10'd999) begin
                            ms_cnt <= 10'd0;
                            if (countdown_digit <= 4'd1) begin
                                countdown_digit <= 4'd0;
                                window_ms       <= base_window;
                                window_load     <= 1'b1;
                                game_active     <= 1'b1;
                                ramp_cnt        <= 8'd0;
                                state           <= S_PLAY;
                            end else begin
                                countdown_digit <= countdown_digit - 4'd1;
                            end
                        end else begin
                            ms_cnt <= ms_cnt + 10'd1;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 16'd1;
                    end
                end

                S_PLAY: begin
                    // A miss wins over a simultaneous hit; the hit is dropped.
                    if (fsm_miss) begin
                        ramp_cnt <= 8'd0;
                        if (lives <= 2'd1) begin
                            lives       <= 2'd0;
                            game_active <= 1'b0;
                            game_over   <= 1'b1;
                            state       <= S_OVER;
                        end else begin
                            lives <= lives - 2'd1;
                        end
                    end else if (fsm_hit) begin
                        if (ramp_cnt == 8'(RAMP_HITS - 1)) begin
                            ramp_cnt    <= 8'd0;
                            window_ms   <= ramped_window;
                            window_load <= 1'b1;
                        end else begin
                            ramp_cnt <= ramp_cnt + 8'd1;
                        end
`ifdef MOLE_ROUND_EXTRA_LIFE_EN
                        hit_total <= hit_total_next;
                        if (life_grant && (lives < 2'(LIVES)))
                            lives <= lives + 2'd1;
`endif
                    end
                end

                S_OVER: begin
                    // Everything holds until abort.
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
